// File: rtl/mem_burst_master_pkg.sv
// Shared widths for the layer controller memory port and the burst master.
package mem_burst_master_pkg;
    localparam int LC_MEM_ADDR_WIDTH = 30;
    localparam int LC_MEM_DATA_WIDTH = 32;
    localparam int TMO_W             = 8;
endpackage

// File: rtl/mem_burst_master.sv
// Burst initiator: one 4-phase MEM_REQ/MEM_ACK_IN transaction per word,
// write data in and read data out over ready/valid, per-word ack timeout.
module mem_burst_master
    import mem_burst_master_pkg::*;
#(
    parameter int ADDR_WIDTH = LC_MEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = LC_MEM_DATA_WIDTH,
    parameter int LEN_WIDTH  = 20,
    parameter int TIMEOUT    = 255
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  CMD_REQ,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [LEN_WIDTH-1:0]  CMD_LEN,
    output logic                  CMD_ACK,
    output logic                  CMD_ERR,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  RD_VALID,
    input  logic                  RD_READY,
    output logic [ADDR_WIDTH-1:0] MEM_ADDR,
    output logic [DATA_WIDTH-1:0] MEM_DATA_OUT,
    output logic                  MEM_REQ,
    output logic                  MEM_WRITE,
    input  logic [DATA_WIDTH-1:0] MEM_DATA_IN,
    input  logic                  MEM_ACK_IN,
    output logic                  BUSY
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_REQ, S_RELEASE, S_DELIVER, S_NEXT, S_DONE
    } state_t;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic                  write_q, write_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic                  wr_ready_q, wr_ready_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_dout_q, mem_dout_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_write_q, mem_write_d;
    logic                  busy_q, busy_d;

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= '0;
            write_q     <= 1'b0;
            tmo_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            wr_ready_q  <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            write_q     <= write_d;
            tmo_q       <= tmo_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            wr_ready_q  <= wr_ready_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            busy_q      <= busy_d;
        end
    end

    // err_q doubles as the abort flag: it is only set by a timeout and
    // only cleared when the next command is latched.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        write_d     = write_q;
        tmo_d       = tmo_q;
        ack_d       = ack_q;
        err_d       = err_q;
        wr_ready_d  = wr_ready_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        mem_addr_d  = mem_addr_q;
        mem_dout_d  = mem_dout_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        case (state_q)
            S_IDLE: if (CMD_REQ && !ack_q) begin
                addr_d  = CMD_ADDR;
                len_d   = CMD_LEN;
                write_d = CMD_WRITE;
                err_d   = 1'b0;
                if (CMD_WRITE) begin
                    wr_ready_d = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_FETCH: if (WR_VALID && wr_ready_q) begin
                mem_dout_d = WR_DATA;
                wr_ready_d = 1'b0;
                state_d    = S_ISSUE;
            end
            S_ISSUE: begin
                mem_addr_d  = addr_q;
                mem_write_d = write_q;
                mem_req_d   = 1'b1;
                tmo_d       = '0;
                state_d     = S_REQ;
            end
            S_REQ: begin
                if (MEM_ACK_IN) begin
                    mem_req_d = 1'b0;
                    if (!write_q) rd_data_d = MEM_DATA_IN;
                    state_d = S_RELEASE;
                end else if (tmo_q == TMO_LAST) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = S_RELEASE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_RELEASE: if (!MEM_ACK_IN) begin
                if (err_q) begin
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else if (!write_q) begin
                    rd_valid_d = 1'b1;
                    state_d    = S_DELIVER;
                end else begin
                    state_d = S_NEXT;
                end
            end
            S_DELIVER: if (RD_READY) begin
                rd_valid_d = 1'b0;
                state_d    = S_NEXT;
            end
            S_NEXT: begin
                if (len_q == '0) begin
                    ack_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    len_d  = len_q - LEN_WIDTH'(1);
                    if (write_q) begin
                        wr_ready_d = 1'b1;
                        state_d    = S_FETCH;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: if (!CMD_REQ) begin
                ack_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    assign CMD_ACK      = ack_q;
    assign CMD_ERR      = err_q;
    assign WR_READY     = wr_ready_q;
    assign RD_DATA      = rd_data_q;
    assign RD_VALID     = rd_valid_q;
    assign MEM_ADDR     = mem_addr_q;
    assign MEM_DATA_OUT = mem_dout_q;
    assign MEM_REQ      = mem_req_q;
    assign MEM_WRITE    = mem_write_q;
    assign BUSY         = busy_q;
endmodule
